// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and defaults for the data-memory responder.
//   dmem_state_t      : responder FSM states (IDLE / WAIT / RESP)
//   DMEM_DEPTH_DEFAULT: default number of 32-bit words
//   DMEM_LAT_DEFAULT  : default request-to-response latency in cycles
//   DMEM_CNT_W        : width of the latency down-counter (LATENCY <= 15)
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_DEPTH_DEFAULT = 256;
  localparam int DMEM_LAT_DEFAULT   = 2;
  localparam int DMEM_CNT_W         = 4;

  // Value loaded into the wait counter on acceptance. WAIT lasts
  // LATENCY-1 cycles (counter LATENCY-2 down to 0); LATENCY=1 skips WAIT.
  function automatic logic [DMEM_CNT_W-1:0] wait_count_load(input int latency);
    if (latency > 1) begin
      return DMEM_CNT_W'(latency - 2);
    end
    return '0;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// CPU <-> data-memory request/response bundle.
//   req_valid  : CPU presents a load/store request
//   req_ready  : responder can accept a request this cycle
//   req_write  : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   resp_valid : one-cycle response strobe
//   resp_rdata : load data (0 when resp_valid is low, and for stores)
//   resp_err   : misaligned-access flag (0 when resp_valid is low)
// Modports: master = CPU side, slave = responder side.
// -----------------------------------------------------------------------------
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_responder_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-wide storage: one synchronous write port and one registered read port,
// written so it maps onto block RAM. Contents are not reset.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write word index
//   i_wdata : write data
//   i_raddr : read word index (sampled on the rising edge)
//   o_rdata : read data, valid the cycle after i_raddr is sampled
// -----------------------------------------------------------------------------
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder for a simple CPU. Accepts one
// load/store in IDLE, waits LATENCY-1 cycles, then strobes resp_valid for
// exactly one cycle. Stores commit at the acceptance edge.
//   clk   : clock, all state updates on its rising edge
//   reset : synchronous active-high reset
//   bus   : dmem_responder_if.slave request/response bundle
// Parameters:
//   DEPTH_WORDS : words of storage (power of two, 2..65536)
//   LATENCY     : acceptance-to-response latency (1..15)
// Optional build macro:
//   DMEM_MISALIGN_ERR_EN : when defined, requests with addr[1:0]!=0 do not
//                          store, return rdata=0 and raise resp_err.
// -----------------------------------------------------------------------------
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter int LATENCY     = DMEM_LAT_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int                    AW       = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = wait_count_load(LATENCY);

  dmem_state_t           r_state;
  dmem_state_t           w_state_next;
  logic [DMEM_CNT_W-1:0] r_cnt;
  logic [DMEM_CNT_W-1:0] w_cnt_next;
  logic [AW-1:0]         r_idx;
  logic                  r_write;
  logic                  r_err;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_resp;
  logic                  w_misalign;
  logic                  w_we;
  logic [AW-1:0]         w_req_idx;
  logic [AW-1:0]         w_rd_idx;
  logic [31:0]           w_rd_data;
  logic                  w_unused_addr;

  // Upper address bits wrap away; the byte offset only matters for the
  // optional misalignment check.
  assign w_req_idx     = bus.req_addr[AW+1:2];
  assign w_unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
  assign w_misalign = (bus.req_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Ready is also held low while reset is asserted so nothing is accepted
  // (and no store commits) during reset.
  assign w_ready  = (r_state == IDLE) && !reset;
  assign w_accept = bus.req_valid && w_ready;
  assign w_we     = w_accept && bus.req_write && !w_misalign;

  // In IDLE the array is addressed straight from the bus so that a
  // LATENCY=1 load has its data registered on the acceptance edge; later
  // the captured index keeps the read port pointed at the same word.
  assign w_rd_idx = (r_state == IDLE) ? w_req_idx : r_idx;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_req_idx),
    .i_wdata (bus.req_wdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY > 1) begin
            w_state_next = WAIT;
            w_cnt_next   = CNT_LOAD;
          end else begin
            w_state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = RESP;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_idx   <= w_req_idx;
        r_write <= bus.req_write;
        r_err   <= w_misalign;
      end
    end
  end

  // A reset arriving while in RESP must not leak a response.
  assign w_resp = (r_state == RESP) && !reset;

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = w_resp;
  assign bus.resp_rdata = (w_resp && !r_write && !r_err) ? w_rd_data : 32'd0;
  assign bus.resp_err   = w_resp && r_err;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored; SHALL be a power of two, 2..65536.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response; SHALL be 1..15.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  CPU presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address, as driven by the ALU result.
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  one-cycle response strobe.
REQ-011 resp_rdata  output  32  load data, valid while resp_valid is high.
REQ-012 resp_err  output  1  misaligned-access flag, valid while resp_valid is high.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 Acceptance: a request is accepted on the edge where req_valid=1 and req_ready=1; addr, wdata and write SHALL be captured at that edge.
REQ-015 IDLE->WAIT on acceptance when LATENCY>1, loading the counter with LATENCY-2; IDLE->RESP on acceptance when LATENCY=1.
REQ-016 WAIT: the counter SHALL decrement each cycle; WAIT->RESP when the counter is 0.
REQ-017 RESP lasts exactly one cycle with resp_valid=1, then RESP->IDLE unconditionally. No response back-pressure exists.
REQ-018 Latency: a request accepted at edge N SHALL produce resp_valid high during cycle N+LATENCY; throughput is one request per LATENCY+1 cycles.
REQ-019 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-020 A store SHALL write the full word at the acceptance edge; its response SHALL carry resp_rdata=0.
REQ-021 A load SHALL return the word stored at the index at the time of the RESP cycle; a store followed by a load to the same address SHALL return the stored value.
REQ-022 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-023 req_valid asserted outside IDLE SHALL be ignored; the request is not queued.

Reset
REQ-024 While reset=1: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0; req_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-025 Reset during WAIT or RESP SHALL abort the transaction without producing a response; a store already accepted remains committed.
REQ-026 Memory contents are not initialised by reset.

Configuration
REQ-027 Macro DMEM_MISALIGN_ERR_EN: when defined, a request with req_addr[1:0]!=0 SHALL suppress the store, return resp_rdata=0 and assert resp_err=1 in its RESP cycle, with unchanged timing.
REQ-028 When DMEM_MISALIGN_ERR_EN is undefined, req_addr[1:0] SHALL be ignored and resp_err SHALL be tied to 0.

Structure
REQ-029 Package mips_mem_pkg SHALL hold the FSM state type (IDLE/WAIT/RESP) and default constants for DEPTH_WORDS and LATENCY.
REQ-030 The storage array SHALL be a sub-module dmem_array (one write port, one registered read port) instantiated once.

Verification
REQ-031 Reset for 2 cycles, then idle: req_ready=1 in cycle 1 after reset; resp_valid, resp_rdata, resp_err stay 0.
REQ-032 LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> each resp_valid arrives 2 cycles after acceptance; the load returns 0xDEADBEEF.
REQ-033 DEPTH_WORDS=256: store 0x12345678 to 0x00000400, load 0x00000000 -> returns 0x12345678 (wrap).
REQ-034 req_valid held high continuously -> accepts once every LATENCY+1 cycles; req_ready=0 in WAIT and RESP.
REQ-035 Reset asserted during WAIT of a load -> no resp_valid; the next request completes normally.
REQ-036 With DMEM_MISALIGN_ERR_EN: store 0xFFFFFFFF to 0x13, load 0x10 -> store resp_err=1; the load returns the prior contents with resp_err=0.
